// File: rtl/seg_pkg.sv
// Shared constants, state encoding and write payload for the segment scanner.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;

  // Active-low "everything off" patterns.
  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] digit;
    logic [NIB_W-1:0] data;
    logic             blank;
  } wr_req_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_sevenseg.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} glyph decoder.
module seg_scan_ctrl_sevenseg
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [SEG_W-1:0] seg_o
);

  // Glyph lookup, 0-9 then A b C d E F.
  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with blanking gaps,
// per-digit blanking and leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DWELL = 50000,
  parameter int unsigned GUARD = 500
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  scan_en,
  input  logic                  lz_en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDX_W-1:0]      wr_digit,
  input  logic [NIB_W-1:0]      wr_data,
  input  logic                  wr_blank,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned CNT_W = $clog2(max_u(DWELL, GUARD) + 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NIB_W-1:0]        nib_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [SEG_W-1:0]        glyph;
  logic [NUM_DIGITS-1:0]   lit_above;
  logic                    lz_acc;
  logic                    digit_dark;
  logic                    wr_fire;
  wr_req_t                 wr_req;

  assign wr_req = '{digit: wr_digit, data: wr_data, blank: wr_blank};

  // Only the digit currently being shown is locked against writes.
  assign wr_ready = (state_q != ST_SHOW) || (wr_req.digit != idx_q);
  assign wr_fire  = wr_valid && wr_ready;

  // Single decoder shared by all digits, fed by the scanned nibble.
  seg_scan_ctrl_sevenseg u_dec (
    .nib_i (nib_q[idx_q]),
    .seg_o (glyph)
  );

  // lit_above[i]: some digit at index >= i is visible and nonzero.
  always_comb begin
    lz_acc    = 1'b0;
    lit_above = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      lz_acc       = lz_acc | (!blank_q[i] && (nib_q[i] != 4'd0));
      lit_above[i] = lz_acc;
    end
  end

  assign digit_dark = blank_q[idx_q] ||
                      (lz_en && (idx_q != '0) && !lit_above[idx_q]);

  // Scan sequencing next-state and next display pattern.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    an_d    = AN_OFF;
    seg_d   = SEG_BLANK;
    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (scan_en) begin
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        an_d  = ~(8'h01 << idx_q);
        seg_d = digit_dark ? SEG_BLANK : glyph;
        if (!scan_en) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DWELL - 1)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (!scan_en) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(GUARD - 1)) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Scan state register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered segment and anode drivers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      seg_q <= SEG_BLANK;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  // Digit nibble and blank-flag storage.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        nib_q[i] <= '0;
      end
      blank_q <= '1;
    end else if (wr_fire) begin
      nib_q[wr_req.digit]   <= wr_req.data;
      blank_q[wr_req.digit] <= wr_req.blank;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with DWELL=4, GUARD=2.
module tb_seg_scan_ctrl;

  localparam int DWELL = 4;
  localparam int GUARD = 2;
  localparam int PER   = DWELL + GUARD;

  logic       clock = 1'b0;
  logic       resetn, scan_en, lz_en, wr_valid, wr_blank;
  logic [2:0] wr_digit;
  logic [3:0] wr_data;
  logic       wr_ready;
  logic [6:0] seg;
  logic [7:0] an;

  seg_scan_ctrl #(.DWELL(DWELL), .GUARD(GUARD)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .scan_en  (scan_en),
    .lz_en    (lz_en),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_digit (wr_digit),
    .wr_data  (wr_data),
    .wr_blank (wr_blank),
    .seg      (seg),
    .an       (an)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] data;
    logic [6:0] seg;
  } glyph_vec_t;

  int checks   = 0;
  int failures = 0;

  // Reference model: scan position counted in cycles since scanning began.
  bit         m_run;
  int         m_p;
  logic [3:0] m_nib   [8];
  bit         m_blank [8];
  bit         m_acc;
  int         m_phase_pre;
  logic       last_ready;
  logic [6:0] glyph_tab [16];
  logic [6:0] exp_seg;
  logic [7:0] exp_an;
  glyph_vec_t gv [16];
  logic [6:0] g_list [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit m_show();
    return m_run && ((m_p % PER) < DWELL);
  endfunction

  function automatic int m_digit();
    return (m_p / PER) % 8;
  endfunction

  function automatic bit m_ready();
    return !(m_show() && (int'(wr_digit) == m_digit()));
  endfunction

  function automatic bit m_dark(input int d);
    int hi;
    if (m_blank[d]) return 1'b1;
    if (!lz_en || d == 0) return 1'b0;
    hi = -1;
    for (int j = 0; j < 8; j++) begin
      if (!m_blank[j] && m_nib[j] != 4'd0) hi = j;
    end
    return d > hi;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_p   = 0;
    for (int j = 0; j < 8; j++) begin
      m_nib[j]   = 4'd0;
      m_blank[j] = 1'b1;
    end
  endtask

  // One clock: check wr_ready before the edge, then an/seg after it.
  task automatic cycle();
    int d;
    #2;
    last_ready = wr_ready;
    chk("wr_ready", wr_ready, m_ready());
    d = m_digit();
    if (m_show()) begin
      exp_an  = ~(8'h01 << d);
      exp_seg = m_dark(d) ? 7'h7F : glyph_tab[m_nib[d]];
    end else begin
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
    end
    m_acc       = resetn && wr_valid && m_ready();
    m_phase_pre = m_run ? (m_p % PER) : -1;
    @(posedge clock);
    if (!resetn) begin
      model_reset();
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
    end else begin
      if (m_acc) begin
        m_nib[int'(wr_digit)]   = wr_data;
        m_blank[int'(wr_digit)] = wr_blank;
      end
      if (!scan_en) m_run = 1'b0;
      else if (!m_run) begin
        m_run = 1'b1;
        m_p   = 0;
      end else m_p = (m_p + 1) % (8 * PER);
    end
    #1;
    chk("an", an, exp_an);
    chk("seg", seg, exp_seg);
  endtask

  task automatic write(input int d, input logic [3:0] v, input logic b);
    wr_valid = 1'b1;
    wr_digit = 3'(d);
    wr_data  = v;
    wr_blank = b;
    cycle();
    wr_valid = 1'b0;
  endtask

  // Advance until the model is at the given digit/phase of a running scan.
  task automatic wait_pos(input int d, input int ph, input string name);
    int n = 0;
    while (!(m_run && m_digit() == d && (m_p % PER) == ph) && n < 200) begin
      cycle();
      n++;
    end
    chk(name, (n >= 200) ? 1 : 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt [8];
    int dark_cnt, prev, n, stalls, acc_phase, lit_cnt, bad;
    bit seen [8];
    logic [6:0] lz_exp [8];
    logic [7:0] tmp;

    for (int k = 0; k < 16; k++) begin
      gv[k]        = '{4'(k), g_list[k]};
      glyph_tab[k] = g_list[k];
    end
    lz_exp = '{7'h12, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    resetn = 1'b0; scan_en = 1'b0; lz_en = 1'b0; wr_valid = 1'b0;
    wr_digit = '0; wr_data = '0; wr_blank = 1'b0;
    model_reset();
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b1;

    // Idle with scanning disabled.
    repeat (20) cycle();
    chk("idle_an", an, 8'hFF);
    chk("idle_seg", seg, 7'h7F);
    chk("idle_ready", wr_ready, 1'b1);

    // Glyph table on digit 0.
    for (int k = 0; k < 16; k++) begin
      scan_en = 1'b0;
      cycle();
      write(0, gv[k].data, 1'b0);
      scan_en = 1'b1;
      cycle();
      cycle();
      chk("glyph_an", an, 8'hFE);
      chk("glyph_seg", seg, gv[k].seg);
    end

    // Digits 0..7 = 0..7, full rotation plus wrap.
    scan_en = 1'b0;
    cycle();
    for (int d = 0; d < 8; d++) write(d, 4'(d), 1'b0);
    scan_en = 1'b1;
    for (int d = 0; d < 8; d++) cnt[d] = 0;
    dark_cnt = 0;
    prev = -1;
    repeat (1 + 8 * PER + DWELL) begin
      cycle();
      if (an == 8'hFF) dark_cnt++;
      else begin
        for (int d = 0; d < 8; d++) begin
          tmp = ~(8'h01 << d);
          if (an == tmp) begin
            cnt[d]++;
            if (d == 3) chk("d3_seg", seg, 7'h30);
            if (prev != d) begin
              if (prev >= 0) chk("order", d, (prev + 1) % 8);
              prev = d;
            end
          end
        end
      end
    end
    chk("dwell_d0", cnt[0], 2 * DWELL);
    for (int d = 1; d < 8; d++) chk("dwell_dn", cnt[d], DWELL);
    chk("dark_cycles", dark_cnt, 1 + 8 * GUARD);

    // Leading-zero suppression with 0x00000A05.
    scan_en = 1'b0;
    cycle();
    write(0, 4'h5, 1'b0);
    write(1, 4'h0, 1'b0);
    write(2, 4'hA, 1'b0);
    for (int d = 3; d < 8; d++) write(d, 4'h0, 1'b0);
    lz_en = 1'b1;
    scan_en = 1'b1;
    for (int d = 0; d < 8; d++) seen[d] = 1'b0;
    repeat (1 + 8 * PER) begin
      cycle();
      for (int d = 0; d < 8; d++) begin
        tmp = ~(8'h01 << d);
        if (an == tmp && !seen[d]) begin
          seen[d] = 1'b1;
          chk("lz_seg", seg, lz_exp[d]);
        end
      end
    end
    n = 0;
    for (int d = 0; d < 8; d++) n += seen[d] ? 1 : 0;
    chk("lz_all_seen", n, 8);
    lz_en = 1'b0;

    // Write to digit 2 while it is being shown stalls until the gap.
    wait_pos(2, 1, "wait_d2");
    wr_valid = 1'b1; wr_digit = 3'd2; wr_data = 4'hF; wr_blank = 1'b0;
    stalls = 0; acc_phase = -1; n = 0;
    while (n < 20) begin
      cycle();
      n++;
      if (!last_ready) stalls++;
      if (m_acc) begin
        acc_phase = m_phase_pre;
        break;
      end
    end
    wr_valid = 1'b0;
    chk("stall_cycles", stalls, DWELL - 1);
    chk("accept_first_gap", acc_phase, DWELL);
    n = 0;
    while (an != 8'hFB && n < 100) begin
      cycle();
      n++;
    end
    chk("wait_d2_again", (n >= 100) ? 1 : 0, 0);
    chk("new_glyph", seg, 7'h0E);

    // Drop scan_en mid-dwell of digit 5, then restart.
    wait_pos(5, 1, "wait_d5");
    scan_en = 1'b0;
    cycle();
    chk("drop_still_lit", an, 8'hDF);
    cycle();
    chk("drop_an", an, 8'hFF);
    chk("drop_seg", seg, 7'h7F);
    cycle();
    scan_en = 1'b1;
    cycle();
    cycle();
    chk("restart_an", an, 8'hFE);

    // Reset in a gap with a concurrent write.
    wait_pos(3, DWELL, "wait_gap");
    resetn = 1'b0;
    wr_valid = 1'b1; wr_digit = 3'd4; wr_data = 4'h9; wr_blank = 1'b0;
    cycle();
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_ready", wr_ready, 1'b1);
    resetn = 1'b1;
    wr_valid = 1'b0;
    lit_cnt = 0; bad = 0;
    repeat (1 + 8 * PER) begin
      cycle();
      if (an != 8'hFF) begin
        lit_cnt++;
        if (seg != 7'h7F) bad++;
      end
    end
    chk("rst_lit_cycles", lit_cnt, 8 * DWELL);
    chk("rst_all_blank", bad, 0);

    // Randomized traffic against the model.
    repeat (1500) begin
      resetn   = ($urandom_range(0, 299) != 0);
      scan_en  = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 59) == 0) lz_en = ~lz_en;
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_digit = 3'($urandom_range(0, 7));
      wr_data  = 4'($urandom_range(0, 15));
      wr_blank = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 50000: clock cycles each digit stays lit (legal range 2..2^20).
REQ-002 Parameter GUARD, default 500: blanking cycles between digits, anti-ghosting (legal range 1..2^16).
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 scan_en  in  1  1 = scanning runs; 0 = display dark.
REQ-006 lz_en  in  1  1 = leading-zero suppression on.
REQ-007 wr_valid  in  1  write request.
REQ-008 wr_ready  out  1  write accepted when wr_valid & wr_ready.
REQ-009 wr_digit  in  3  target digit index 0..7 (0 = least significant).
REQ-010 wr_data  in  4  hex nibble for target digit.
REQ-011 wr_blank  in  1  1 = force target digit dark.
REQ-012 seg  out  7  active-low segments {g,f,e,d,c,b,a}, hex glyphs 0-F.
REQ-013 an  out  8  active-low digit enables, one-hot-low or all ones.

Function
REQ-014 Holds 8 nibble registers and 8 blank flags; accepted write updates both for wr_digit on the accepting edge.
REQ-015 FSM states: IDLE, SHOW, GAP.
REQ-016 IDLE: an = 8'hFF, seg = 7'h7F; scan_en=1 -> SHOW with digit index 0, dwell counter cleared.
REQ-017 SHOW: an drives bit[idx] low only; lasts exactly DWELL cycles, then -> GAP.
REQ-018 GAP: an = 8'hFF, seg = 7'h7F; lasts exactly GUARD cycles, then idx = idx+1 mod 8 (7 wraps to 0) -> SHOW.
REQ-019 scan_en=0 in SHOW or GAP -> IDLE on the next edge; idx resets to 0.
REQ-020 seg and an are registered; they reflect the state/idx one cycle after the state is entered.
REQ-021 In SHOW, seg = hex glyph of nibble[idx], unless digit is dark, then 7'h7F with an bit still low.
REQ-022 Digit dark when blank[idx]=1, or lz_en=1 and idx > index of highest non-blank nonzero nibble; digit 0 never suppressed by lz_en.
REQ-023 wr_ready = 1 in IDLE and GAP; in SHOW, 0 only when wr_digit == idx (no glyph change mid-dwell); writes to other digits accepted in SHOW.
REQ-024 Write accepted on the cycle SHOW->GAP transition occurs takes effect before that digit is next shown.
REQ-025 wr_valid held while wr_ready=0 shall complete no later than the first GAP cycle.
REQ-026 Dwell and guard counters saturate-free: width ceil(log2(max(DWELL,GUARD)+1)), count 0..N-1 then clear.

Reset
REQ-027 resetn=0 at an edge: state IDLE, idx 0, counters 0, nibbles 0, blank flags all 1, an = 8'hFF, seg = 7'h7F, wr_ready = 1 on the following cycle.
REQ-028 Reset mid-SHOW/GAP overrides all activity; a write presented in the reset cycle is discarded.

Structure
REQ-029 State encoding and glyph/blank constants (7'h7F, 8'hFF) reside in shared package seg_pkg.
REQ-030 Exactly one sevenseg decoder sub-module instance, shared across digits, fed by nibble[idx].

Verification (DWELL=4, GUARD=2)
REQ-031 Reset, scan_en=0 -> an=8'hFF, seg=7'h7F for 20 cycles, wr_ready=1.
REQ-032 Write digits 0..7 = 0..7, blank=0, scan_en=1 -> each an bit low 4 cycles in order 0..7, 2-cycle dark gaps, seg digit 3 = 7'h30, wrap back to digit 0 after digit 7.
REQ-033 Nibbles = 0x00000A05, lz_en=1 -> digits 0,1,2 lit (0 shows 7'h40), digits 3..7 seg=7'h7F.
REQ-034 wr_valid to digit 2 while digit 2 in SHOW -> wr_ready=0 until GAP; write completes first GAP cycle; new glyph on next digit-2 SHOW.
REQ-035 Drop scan_en mid-SHOW of digit 5 -> IDLE next edge, an=8'hFF one cycle later; re-enable restarts at digit 0.
REQ-036 resetn=0 mid-GAP with concurrent write -> all outputs at reset values, write discarded, blank flags all 1.
